// File: rtl/tlb_op_seq_if.sv
// Bundle of request, CP0, TLB-array and CP0-update signals for tlb_op_seq.
// master: the pipeline/CP0/TLB-array side; slave: the sequencer.
interface tlb_op_seq_if;
  logic         op_valid;
  logic [1:0]   op_type;
  logic         kill;
  logic         op_ready;
  logic         busy;
  logic [31:0]  cp0_entryhi;
  logic [31:0]  cp0_pagemask;
  logic [31:0]  cp0_entrylo0;
  logic [31:0]  cp0_entrylo1;
  logic [31:0]  cp0_index;
  logic [31:0]  cp0_random;
  logic [4:0]   tlb_raddr;
  logic [127:0] tlb_rdata;
  logic         tlb_we;
  logic [4:0]   tlb_waddr;
  logic [127:0] tlb_wdata;
  logic [2:0]   upd_type;
  logic [127:0] upd_data;
  logic [31:0]  upd_index;
  logic         done;

  modport master (
    output op_valid, op_type, kill,
    output cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_index, cp0_random,
    output tlb_rdata,
    input  op_ready, busy, tlb_raddr, tlb_we, tlb_waddr, tlb_wdata,
    input  upd_type, upd_data, upd_index, done
  );

  modport slave (
    input  op_valid, op_type, kill,
    input  cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_index, cp0_random,
    input  tlb_rdata,
    output op_ready, busy, tlb_raddr, tlb_we, tlb_waddr, tlb_wdata,
    output upd_type, upd_data, upd_index, done
  );
endinterface

// File: rtl/tlb_op_seq.sv
// TLB instruction sequencer (TLBP / TLBR / TLBWI / TLBWR).
// Optional feature macro: TLBWR_RANDOM_EN -- when defined, TLBWR writes the
// entry selected by cp0_random[4:0]; otherwise TLBWR behaves like TLBWI.
module tlb_op_seq (
  input logic        clk,
  input logic        rst,
  tlb_op_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PROBE, READ, WRITE, DONE} state_t;

  state_t        state, state_next;
  logic [1:0]    op_reg, op_next;
  logic [31:0]   hi_reg, hi_next, mask_reg, mask_next;
  logic [31:0]   lo0_reg, lo0_next, lo1_reg, lo1_next;
  logic [4:0]    waddr_reg, waddr_next;
  logic [4:0]    scan_reg, scan_next;
  logic [127:0]  upd_data_reg, upd_data_next;
  logic [31:0]   upd_index_reg, upd_index_next;
  logic [4:0]    raddr;
  logic [4:0]    target;
  logic          hit;
  logic          unused_bits;

  // Index/Random are only needed for the write target, so the snapshot of
  // those two registers is reduced to the 5-bit target taken at accept time.
`ifdef TLBWR_RANDOM_EN
  assign target = (bus.op_type == 2'b11) ? bus.cp0_random[4:0] : bus.cp0_index[4:0];
`else
  assign target = bus.cp0_index[4:0];
`endif
  assign unused_bits = ^{bus.cp0_index[31:5], bus.cp0_random};

  // Probe compare of the entry currently on tlb_rdata against the snapshot.
  always_comb begin
    logic [31:0] e_hi, e_mask;
    e_hi   = bus.tlb_rdata[127:96];
    e_mask = bus.tlb_rdata[95:64];
    hit = ((e_hi[31:13] & ~e_mask[31:13]) == (hi_reg[31:13] & ~mask_reg[31:13])) &&
          ((bus.tlb_rdata[32] & bus.tlb_rdata[0]) || (e_hi[7:0] == hi_reg[7:0]));
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_reg        <= 2'b00;
      hi_reg        <= '0;
      mask_reg      <= '0;
      lo0_reg       <= '0;
      lo1_reg       <= '0;
      waddr_reg     <= '0;
      scan_reg      <= '0;
      upd_data_reg  <= '0;
      upd_index_reg <= '0;
    end else begin
      state         <= state_next;
      op_reg        <= op_next;
      hi_reg        <= hi_next;
      mask_reg      <= mask_next;
      lo0_reg       <= lo0_next;
      lo1_reg       <= lo1_next;
      waddr_reg     <= waddr_next;
      scan_reg      <= scan_next;
      upd_data_reg  <= upd_data_next;
      upd_index_reg <= upd_index_next;
    end
  end

  // Next-state, snapshot capture, probe scan and read-port address.
  always_comb begin
    state_next     = state;
    op_next        = op_reg;
    hi_next        = hi_reg;
    mask_next      = mask_reg;
    lo0_next       = lo0_reg;
    lo1_next       = lo1_reg;
    waddr_next     = waddr_reg;
    scan_next      = scan_reg;
    upd_data_next  = upd_data_reg;
    upd_index_next = upd_index_reg;
    raddr          = 5'd0;
    case (state)
      IDLE: begin
        // TLBR reads live Index so the entry arrives in the READ cycle;
        // TLBP starts its scan at entry 0.
        raddr = (bus.op_type == 2'b01) ? bus.cp0_index[4:0] : 5'd0;
        if (bus.op_valid) begin
          op_next   = bus.op_type;
          hi_next   = bus.cp0_entryhi;
          mask_next = bus.cp0_pagemask;
          lo0_next  = bus.cp0_entrylo0;
          lo1_next  = bus.cp0_entrylo1;
          scan_next = 5'd0;
          case (bus.op_type)
            2'b00:   state_next = PROBE;
            2'b01:   state_next = READ;
            default: begin
              state_next = WRITE;
              waddr_next = target;
            end
          endcase
        end
      end
      PROBE: begin
        // Prefetch the next entry while comparing the current one.
        raddr = scan_reg + 5'd1;
        if (bus.kill) begin
          state_next = IDLE;
        end else if (hit) begin
          state_next     = DONE;
          upd_index_next = {27'd0, scan_reg};
        end else if (scan_reg == 5'd31) begin
          state_next     = DONE;
          upd_index_next = 32'h8000_0000;
        end else begin
          scan_next = scan_reg + 5'd1;
        end
      end
      READ: begin
        if (bus.kill) begin
          state_next = IDLE;
        end else begin
          state_next    = DONE;
          upd_data_next = bus.tlb_rdata;
        end
      end
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; the write strobe is gated by rst so a reset during WRITE never commits.
  always_comb begin
    bus.op_ready  = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.tlb_raddr = raddr;
    bus.tlb_we    = (state == WRITE) && !rst;
    bus.tlb_waddr = waddr_reg;
    bus.tlb_wdata = {hi_reg, mask_reg, lo0_reg, lo1_reg};
    bus.done      = (state == DONE);
    bus.upd_type  = 3'b000;
    if (state == DONE) begin
      if (op_reg == 2'b00)      bus.upd_type = 3'b001;
      else if (op_reg == 2'b01) bus.upd_type = 3'b010;
    end
    bus.upd_data  = upd_data_reg;
    bus.upd_index = upd_index_reg;
  end

endmodule

// File: tb/tb_tlb_op_seq.sv
// Self-checking bench for tlb_op_seq: behavioural TLB array, scoreboard of
// expected completions, one task per scenario.
module tb_tlb_op_seq;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  tlb_op_seq_if bus();
  tlb_op_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [2:0]   ut;
    logic [31:0]  ui;
    logic [127:0] ud;
    bit           chk_idx;
    bit           chk_data;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural TLB array: one-cycle read latency, write port from DUT,
  // a bench-side poke port, and default contents reloaded during rst.
  logic [127:0] mem [32];
  logic         poke_en = 1'b0;
  logic [4:0]   poke_addr = '0;
  logic [127:0] poke_data = '0;

  function automatic logic [127:0] dflt(input int i);
    logic [31:0] hi, lo;
    hi = 32'hF000_0001 | (32'(i) << 13);
    lo = 32'(i) << 6;
    return {hi, 32'h0, lo, lo};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= dflt(i);
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      if (bus.tlb_we) mem[bus.tlb_waddr] <= bus.tlb_wdata;
    end
    bus.tlb_rdata <= mem[bus.tlb_raddr];
  end

  // Record every write strobe seen by the array.
  int           we_count = 0;
  int           we_cyc = 0;
  logic [4:0]   we_addr = '0;
  logic [127:0] we_data = '0;
  always @(negedge clk) begin
    if (bus.tlb_we === 1'b1) begin
      we_count <= we_count + 1;
      we_cyc   <= cyc;
      we_addr  <= bus.tlb_waddr;
      we_data  <= bus.tlb_wdata;
    end
  end

  task automatic poke(input logic [4:0] a, input logic [127:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] t, output int tacc);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_type = t; tacc = cyc;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op_type = 2'b00;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int at,
                           output logic [2:0] ut, output logic [31:0] ui,
                           output logic [127:0] ud, output int busy_cnt);
    seen = 1'b0; at = 0; ut = '0; ui = '0; ud = '0; busy_cnt = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        seen = 1'b1; at = cyc; ut = bus.upd_type; ui = bus.upd_index; ud = bus.upd_data;
      end
    end
    if (seen) $display("txn done cyc=%0d upd_type=%b upd_index=%h", at, ut, ui);
  endtask

  task automatic set_cp0(input logic [31:0] hi, mask, lo0, lo1, idx, rnd);
    bus.cp0_entryhi = hi; bus.cp0_pagemask = mask; bus.cp0_entrylo0 = lo0;
    bus.cp0_entrylo1 = lo1; bus.cp0_index = idx; bus.cp0_random = rnd;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.op_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.tlb_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus.tlb_we); end
    n_cmp++; if (bus.upd_type !== 3'b000) begin n_bad++; $display("FAIL rst_upd_type: got %b want 000", bus.upd_type); end
    n_cmp++; if (bus.upd_data !== 128'd0) begin n_bad++; $display("FAIL rst_upd_data: got %h want 0", bus.upd_data); end
    n_cmp++; if (bus.upd_index !== 32'd0) begin n_bad++; $display("FAIL rst_upd_index: got %h want 0", bus.upd_index); end
    n_cmp++; if (bus.tlb_raddr !== 5'd0) begin n_bad++; $display("FAIL rst_raddr: got %0d want 0", bus.tlb_raddr); end
    n_cmp++; if (bus.tlb_waddr !== 5'd0) begin n_bad++; $display("FAIL rst_waddr: got %0d want 0", bus.tlb_waddr); end
  endtask

  // Runs one probe and checks cycle, type and index against the scoreboard.
  task automatic test_probe(input string name, input logic [31:0] hi,
                            input int lat, input logic [31:0] idx, input int busy_exp);
    int tacc, at, bc; bit seen; logic [2:0] ut; logic [31:0] ui; logic [127:0] ud;
    exp_t e;
    set_cp0(hi, 32'h0, 32'h0, 32'h0, 32'd0, 32'd0);
    start_op(2'b00, tacc);
    exp_q.push_back('{cyc: tacc + lat, ut: 3'b001, ui: idx, ud: '0, chk_idx: 1'b1, chk_data: 1'b0});
    bus.cp0_entryhi = 32'hFFFF_FFFF;
    wait_done(40, seen, at, ut, ui, ud, bc);
    n_cmp++;
    if (!seen || exp_q.size() == 0) begin
      n_bad++; $display("FAIL %s_timeout: got no done want done", name);
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if (at !== e.cyc) begin n_bad++; $display("FAIL %s_cycle: got %0d want %0d", name, at - tacc, e.cyc - tacc); end
      n_cmp++; if (ut !== e.ut) begin n_bad++; $display("FAIL %s_type: got %b want %b", name, ut, e.ut); end
      if (e.chk_idx) begin
        n_cmp++; if (ui !== e.ui) begin n_bad++; $display("FAIL %s_index: got %h want %h", name, ui, e.ui); end
      end
      if (busy_exp > 0) begin
        n_cmp++; if (bc !== busy_exp) begin n_bad++; $display("FAIL %s_busy: got %0d want %0d", name, bc, busy_exp); end
      end
    end
  endtask

  task automatic test_probe_hit;
    poke(5'd5, {32'h0040_0012, 32'h0, 32'h0, 32'h0});
    test_probe("probe_hit5", 32'h0040_0012, 7, 32'd5, 7);
  endtask

  task automatic test_probe_miss;
    test_probe("probe_miss", 32'h1234_5000, 33, 32'h8000_0000, 33);
  endtask

  task automatic test_probe_global;
    poke(5'd3, {32'h0080_0007, 32'h0, 32'h1, 32'h1});
    test_probe("probe_global", 32'h0080_0022, 5, 32'd3, 0);
    poke(5'd9, {32'h0080_0022, 32'h0, 32'h0, 32'h0});
    test_probe("probe_first", 32'h0080_0022, 5, 32'd3, 0);
  endtask

  task automatic test_write_read;
    int tacc, at, bc, wc0; bit seen; logic [2:0] ut; logic [31:0] ui; logic [127:0] ud;
    logic [127:0] ent;
    exp_t e;
    ent = {32'h0AAA_A000, 32'h0, 32'h0000_1234, 32'h0000_5678};
    wc0 = we_count;
    set_cp0(32'h0AAA_A000, 32'h0, 32'h0000_1234, 32'h0000_5678, 32'd12, 32'd25);
    start_op(2'b10, tacc);
    exp_q.push_back('{cyc: tacc + 2, ut: 3'b000, ui: '0, ud: '0, chk_idx: 1'b0, chk_data: 1'b0});
    bus.cp0_entrylo0 = 32'hDEAD_BEEF; bus.cp0_index = 32'd7;
    wait_done(10, seen, at, ut, ui, ud, bc);
    n_cmp++;
    if (!seen || exp_q.size() == 0) begin
      n_bad++; $display("FAIL tlbwi_timeout: got no done want done");
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if (at !== e.cyc) begin n_bad++; $display("FAIL tlbwi_cycle: got %0d want %0d", at - tacc, e.cyc - tacc); end
      n_cmp++; if (ut !== e.ut) begin n_bad++; $display("FAIL tlbwi_type: got %b want %b", ut, e.ut); end
    end
    n_cmp++; if (we_count !== wc0 + 1) begin n_bad++; $display("FAIL tlbwi_we_count: got %0d want %0d", we_count - wc0, 1); end
    n_cmp++; if (we_cyc !== tacc + 1) begin n_bad++; $display("FAIL tlbwi_we_cycle: got %0d want %0d", we_cyc - tacc, 1); end
    n_cmp++; if (we_addr !== 5'd12) begin n_bad++; $display("FAIL tlbwi_waddr: got %0d want 12", we_addr); end
    n_cmp++; if (we_data !== ent) begin n_bad++; $display("FAIL tlbwi_wdata: got %h want %h", we_data, ent); end

    bus.cp0_index = 32'd12;
    start_op(2'b01, tacc);
    exp_q.push_back('{cyc: tacc + 2, ut: 3'b010, ui: '0, ud: ent, chk_idx: 1'b0, chk_data: 1'b1});
    wait_done(10, seen, at, ut, ui, ud, bc);
    n_cmp++;
    if (!seen || exp_q.size() == 0) begin
      n_bad++; $display("FAIL tlbr_timeout: got no done want done");
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if (at !== e.cyc) begin n_bad++; $display("FAIL tlbr_cycle: got %0d want %0d", at - tacc, e.cyc - tacc); end
      n_cmp++; if (ut !== e.ut) begin n_bad++; $display("FAIL tlbr_type: got %b want %b", ut, e.ut); end
      n_cmp++; if (ud !== e.ud) begin n_bad++; $display("FAIL tlbr_data: got %h want %h", ud, e.ud); end
    end
  endtask

  task automatic test_tlbwr_target;
    int tacc, at, bc, wc0; bit seen; logic [2:0] ut; logic [31:0] ui; logic [127:0] ud;
    logic [4:0] want;
`ifdef TLBWR_RANDOM_EN
    want = 5'd20;
`else
    want = 5'd2;
`endif
    wc0 = we_count;
    set_cp0(32'h0BBB_B000, 32'h0, 32'h0, 32'h0, 32'd2, 32'd20);
    start_op(2'b11, tacc);
    wait_done(10, seen, at, ut, ui, ud, bc);
    n_cmp++; if (we_count !== wc0 + 1) begin n_bad++; $display("FAIL tlbwr_we_count: got %0d want 1", we_count - wc0); end
    n_cmp++; if (we_addr !== want) begin n_bad++; $display("FAIL tlbwr_waddr: got %0d want %0d", we_addr, want); end
    n_cmp++; if (at !== tacc + 2) begin n_bad++; $display("FAIL tlbwr_cycle: got %0d want 2", at - tacc); end
  endtask

  task automatic test_kill_probe;
    int tacc, dcnt;
    set_cp0(32'h1234_5000, 32'h0, 32'h0, 32'h0, 32'd0, 32'd0);
    start_op(2'b00, tacc);
    repeat (3) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk); #1 bus.kill = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill_busy: got %b want 0 at T+%0d", bus.busy, cyc - tacc); end
    n_cmp++; if (bus.upd_type !== 3'b000) begin n_bad++; $display("FAIL kill_upd_type: got %b want 000", bus.upd_type); end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dcnt++;
      @(negedge clk);
    end
    n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL kill_done: got %0d pulses want 0", dcnt); end
  endtask

  task automatic test_kill_write_ignored;
    int tacc, at, bc, wc0; bit seen; logic [2:0] ut; logic [31:0] ui; logic [127:0] ud;
    wc0 = we_count;
    set_cp0(32'h0CCC_C000, 32'h0, 32'h0, 32'h0, 32'd4, 32'd0);
    start_op(2'b10, tacc);
    bus.kill = 1'b1;
    wait_done(10, seen, at, ut, ui, ud, bc);
    bus.kill = 1'b0;
    n_cmp++; if (we_count !== wc0 + 1) begin n_bad++; $display("FAIL killwr_we_count: got %0d want 1", we_count - wc0); end
    n_cmp++; if (!seen || at !== tacc + 2) begin n_bad++; $display("FAIL killwr_done: got seen=%0d T+%0d want T+2", seen, at - tacc); end
  endtask

  task automatic test_back_to_back;
    int tacc, at1, at2, bc; bit s1, s2; logic [2:0] ut1, ut2; logic [31:0] ui;
    logic [127:0] ud1, ud2, ent;
    exp_t e;
    ent = {32'h0AAA_A000, 32'h0, 32'h0000_1234, 32'h0000_5678};
    bus.cp0_index = 32'd12;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_type = 2'b01; tacc = cyc;
    exp_q.push_back('{cyc: tacc + 2, ut: 3'b010, ui: '0, ud: ent, chk_idx: 1'b0, chk_data: 1'b1});
    exp_q.push_back('{cyc: tacc + 5, ut: 3'b010, ui: '0, ud: ent, chk_idx: 1'b0, chk_data: 1'b1});
    fork
      begin
        repeat (4) @(posedge clk);
        #1 bus.op_valid = 1'b0; bus.op_type = 2'b00;
      end
      begin
        wait_done(10, s1, at1, ut1, ui, ud1, bc);
        wait_done(10, s2, at2, ut2, ui, ud2, bc);
      end
    join
    n_cmp++;
    if (!s1 || exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_first: got no done want done"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (at1 !== e.cyc) begin n_bad++; $display("FAIL b2b_cycle1: got %0d want %0d", at1 - tacc, e.cyc - tacc); end
      n_cmp++; if (ud1 !== e.ud) begin n_bad++; $display("FAIL b2b_data1: got %h want %h", ud1, e.ud); end
    end
    n_cmp++;
    if (!s2 || exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_second: got no done want done"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (at2 !== e.cyc) begin n_bad++; $display("FAIL b2b_cycle2: got %0d want %0d", at2 - tacc, e.cyc - tacc); end
      n_cmp++; if (ut2 !== e.ut) begin n_bad++; $display("FAIL b2b_type2: got %b want %b", ut2, e.ut); end
    end
  endtask

  task automatic test_reset_mid_write;
    int tacc, wc0;
    wc0 = we_count;
    set_cp0(32'h0DDD_D000, 32'h0, 32'h0, 32'h0, 32'd6, 32'd0);
    start_op(2'b10, tacc);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.tlb_we !== 1'b0) begin n_bad++; $display("FAIL rstwr_we: got %b want 0", bus.tlb_we); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (we_count !== wc0) begin n_bad++; $display("FAIL rstwr_we_count: got %0d want 0", we_count - wc0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstwr_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstwr_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.upd_data !== 128'd0) begin n_bad++; $display("FAIL rstwr_upd_data: got %h want 0", bus.upd_data); end
    n_cmp++; if (bus.upd_index !== 32'd0) begin n_bad++; $display("FAIL rstwr_upd_index: got %h want 0", bus.upd_index); end
    n_cmp++; if (bus.tlb_waddr !== 5'd0) begin n_bad++; $display("FAIL rstwr_waddr: got %0d want 0", bus.tlb_waddr); end
    n_cmp++; if (bus.upd_type !== 3'b000) begin n_bad++; $display("FAIL rstwr_upd_type: got %b want 000", bus.upd_type); end
  endtask

  initial begin
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_type = 2'b00; bus.kill = 1'b0;
    set_cp0(32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_probe_hit();
    test_probe_miss();
    test_probe_global();
    test_kill_probe();
    test_write_read();
    test_tlbwr_target();
    test_kill_write_ignored();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
